// File: rtl/alu_arbiter_if.sv
// Requester, result and shared-ALU signals of the ALU arbiter, grouped into one bundle.
// The slave modport is the arbiter; the master modport is the requester/ALU side.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             r0_valid;
    logic             r1_valid;
    logic [2:0]       r0_op;
    logic [2:0]       r1_op;
    logic [WIDTH-1:0] r0_a;
    logic [WIDTH-1:0] r0_b;
    logic [WIDTH-1:0] r1_a;
    logic [WIDTH-1:0] r1_b;
    logic             r0_ready;
    logic             r1_ready;
    logic             r0_done;
    logic             r1_done;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             err;
    logic             busy;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;

    modport slave (
        input  r0_valid, r1_valid, r0_op, r1_op, r0_a, r0_b, r1_a, r1_b,
        input  alu_result, alu_flags,
        output r0_ready, r1_ready, r0_done, r1_done, result, flags, err, busy,
        output alu_a, alu_b, alu_ctrl
    );

    modport master (
        output r0_valid, r1_valid, r0_op, r1_op, r0_a, r0_b, r1_a, r1_b,
        output alu_result, alu_flags,
        input  r0_ready, r1_ready, r0_done, r1_done, result, flags, err, busy,
        input  alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU: IDLE grants/latches, EXEC drives the ALU.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise r0 has fixed priority.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic [2:0] OP_MUL = 3'b100;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             grant0, grant1;
    logic             accept;
    logic             illegal;
    logic             exec_ok;
`ifdef ALU_ARB_RR_EN
    logic             rr_q, rr_d;
`endif

    // rr_q set means r1 gets the next contested grant
    always_comb begin
`ifdef ALU_ARB_RR_EN
        grant0 = bus.r0_valid & (~bus.r1_valid | ~rr_q);
        grant1 = bus.r1_valid & (~bus.r0_valid | rr_q);
`else
        grant0 = bus.r0_valid;
        grant1 = bus.r1_valid & ~bus.r0_valid;
`endif
    end

    assign bus.r0_ready = (state_q == IDLE) & grant0;
    assign bus.r1_ready = (state_q == IDLE) & grant1;
    assign accept       = bus.r0_ready | bus.r1_ready;
    assign illegal      = (op_q > OP_MUL);
    assign exec_ok      = (state_q == EXEC) & ~illegal;

    assign bus.alu_a    = exec_ok ? a_q : '0;
    assign bus.alu_b    = exec_ok ? b_q : '0;
    assign bus.alu_ctrl = exec_ok ? op_q : 3'b000;
    assign bus.result   = result_q;
    assign bus.flags    = flags_q;
    assign bus.err      = err_q;
    assign bus.r0_done  = done0_q;
    assign bus.r1_done  = done1_q;
    assign bus.busy     = (state_q == EXEC);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
`ifdef ALU_ARB_RR_EN
        rr_d     = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    id_d    = bus.r1_ready;
                    op_d    = bus.r1_ready ? bus.r1_op : bus.r0_op;
                    a_d     = bus.r1_ready ? bus.r1_a  : bus.r0_a;
                    b_d     = bus.r1_ready ? bus.r1_b  : bus.r0_b;
`ifdef ALU_ARB_RR_EN
                    rr_d    = bus.r0_ready;
`endif
                end
            end
            EXEC: begin
                state_d  = IDLE;
                done0_d  = ~id_q;
                done1_d  = id_q;
                err_d    = illegal;
                result_d = illegal ? '0 : bus.alu_result;
                flags_d  = illegal ? 4'b0000 : bus.alu_flags;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= 3'b000;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= 4'b0000;
            err_q    <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
`ifdef ALU_ARB_RR_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
`ifdef ALU_ARB_RR_EN
            rr_q     <= rr_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural shared ALU, expected-result queue, directed and random scenarios.
module tb_alu_arbiter;
    localparam int W = 32;

    typedef struct packed {
        logic         id;
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         er;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];

    alu_arbiter_if #(.WIDTH(W)) bus ();

    alu_arbiter #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [W+3:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        s = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = a * b;
            default: r = '0;
        endcase
        return {r, r[W-1], (r == '0), c, v};
    endfunction

    function automatic exp_t mk(input logic id, input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b);
        exp_t         e;
        logic [W+3:0] t;
        t  = alu_fn(op, a, b);
        e.id = id;
        if (op > 3'b100) begin
            e.res = '0;
            e.flg = 4'b0000;
            e.er  = 1'b1;
        end else begin
            e.res = t[W+3:4];
            e.flg = t[3:0];
            e.er  = 1'b0;
        end
        return e;
    endfunction

    always_comb begin
        {bus.alu_result, bus.alu_flags} = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.r0_valid = 1'b0; bus.r0_op = 3'b000; bus.r0_a = '0; bus.r0_b = '0;
        bus.r1_valid = 1'b0; bus.r1_op = 3'b000; bus.r1_a = '0; bus.r1_b = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({bus.r0_done, bus.r1_done, bus.busy, bus.err} !== 4'b0000)
            $display("FAIL reset_ctrl: got done0/done1/busy/err=%b want 0000",
                     {bus.r0_done, bus.r1_done, bus.busy, bus.err});
        else passed++;
        checks++;
        if (bus.result !== '0 || bus.flags !== 4'b0000)
            $display("FAIL reset_result: got %h/%b want 0/0000", bus.result, bus.flags);
        else passed++;
        #1 reset = 1'b0;
        step();
        checks++;
        if ({bus.r0_ready, bus.r1_ready} !== 2'b00)
            $display("FAIL idle_no_ready: got %b want 00", {bus.r0_ready, bus.r1_ready});
        else passed++;
        checks++;
        if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_ctrl !== 3'b000)
            $display("FAIL idle_alu_zero: got %h %h %b want 0 0 000", bus.alu_a, bus.alu_b, bus.alu_ctrl);
        else passed++;
    endtask

    task automatic test_add_overflow();
        exp_t e;
        bus.r0_valid = 1'b1; bus.r0_op = 3'b000; bus.r0_a = 32'h7FFF_FFFF; bus.r0_b = 32'h1;
        #1;
        checks++;
        if ({bus.r0_ready, bus.r1_ready} !== 2'b10)
            $display("FAIL add_ready: got %b want 10", {bus.r0_ready, bus.r1_ready});
        else passed++;
        sb.push_back('{id: 1'b0, res: 32'h8000_0000, flg: 4'b1001, er: 1'b0});
        step();
        bus.r0_valid = 1'b0; bus.r0_op = 3'b001; bus.r0_a = 32'hDEAD_BEEF; bus.r0_b = 32'h5;
        bus.r1_valid = 1'b1; bus.r1_op = 3'b010;
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.r1_ready !== 1'b0 || bus.r0_done !== 1'b0)
            $display("FAIL add_exec: got busy=%b r1_ready=%b done=%b want 1 0 0",
                     bus.busy, bus.r1_ready, bus.r0_done);
        else passed++;
        checks++;
        if (bus.alu_a !== 32'h7FFF_FFFF || bus.alu_b !== 32'h1 || bus.alu_ctrl !== 3'b000)
            $display("FAIL add_alu_in: got %h %h %b want 7fffffff 00000001 000",
                     bus.alu_a, bus.alu_b, bus.alu_ctrl);
        else passed++;
        bus.r1_valid = 1'b0;
        step();
        e = sb.pop_front();
        checks++;
        if ({bus.r0_done, bus.r1_done} !== {~e.id, e.id})
            $display("FAIL add_done: got %b want %b", {bus.r0_done, bus.r1_done}, {~e.id, e.id});
        else passed++;
        checks++;
        if (bus.result !== e.res || bus.flags !== e.flg || bus.err !== e.er)
            $display("FAIL add_result: got %h/%b/%b want %h/%b/%b",
                     bus.result, bus.flags, bus.err, e.res, e.flg, e.er);
        else passed++;
        step();
        checks++;
        if (bus.r0_done !== 1'b0 || bus.result !== 32'h8000_0000 || bus.busy !== 1'b0)
            $display("FAIL add_hold: got done=%b result=%h busy=%b want 0 80000000 0",
                     bus.r0_done, bus.result, bus.busy);
        else passed++;
    endtask

    task automatic test_illegal();
        exp_t e;
        bus.r0_valid = 1'b1; bus.r0_op = 3'b111; bus.r0_a = 32'h1234; bus.r0_b = 32'h5678;
        #1;
        sb.push_back('{id: 1'b0, res: '0, flg: 4'b0000, er: 1'b1});
        step();
        bus.r0_valid = 1'b0;
        #1;
        checks++;
        if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_ctrl !== 3'b000 || bus.busy !== 1'b1)
            $display("FAIL illegal_alu_in: got %h %h %b busy=%b want 0 0 000 1",
                     bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.busy);
        else passed++;
        step();
        e = sb.pop_front();
        checks++;
        if (bus.r0_done !== 1'b1 || bus.result !== e.res || bus.flags !== e.flg || bus.err !== e.er)
            $display("FAIL illegal_done: got done=%b %h/%b/%b want 1 %h/%b/%b",
                     bus.r0_done, bus.result, bus.flags, bus.err, e.res, e.flg, e.er);
        else passed++;
        step();
        checks++;
        if (bus.err !== 1'b0)
            $display("FAIL illegal_err_clear: got %b want 0", bus.err);
        else passed++;
    endtask

    task automatic test_sub_zero();
        exp_t e;
        bus.r1_valid = 1'b1; bus.r1_op = 3'b001; bus.r1_a = 32'd5; bus.r1_b = 32'd5;
        #1;
        checks++;
        if ({bus.r0_ready, bus.r1_ready} !== 2'b01)
            $display("FAIL sub_ready: got %b want 01", {bus.r0_ready, bus.r1_ready});
        else passed++;
        sb.push_back('{id: 1'b1, res: '0, flg: 4'b0110, er: 1'b0});
        step();
        bus.r1_valid = 1'b0;
        step();
        e = sb.pop_front();
        checks++;
        if ({bus.r0_done, bus.r1_done} !== 2'b01)
            $display("FAIL sub_done: got %b want 01", {bus.r0_done, bus.r1_done});
        else passed++;
        checks++;
        if (bus.result !== e.res || bus.flags !== e.flg || bus.err !== e.er)
            $display("FAIL sub_result: got %h/%b/%b want %h/%b/%b",
                     bus.result, bus.flags, bus.err, e.res, e.flg, e.er);
        else passed++;
        step();
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_order;
        logic [3:0] got_order;
        int         acc_cyc[4];
        int         n_acc;
        int         n_done;
        logic       both_seen;
        logic       bad_spacing;
        logic       acc0;
        logic       acc1;
        exp_t       e;
`ifdef ALU_ARB_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif
        got_order = 4'b0000;
        n_acc = 0;
        n_done = 0;
        both_seen = 1'b0;
        bad_spacing = 1'b0;
        bus.r0_valid = 1'b1; bus.r0_op = 3'b000; bus.r0_a = 32'd3; bus.r0_b = 32'd4;
        bus.r1_valid = 1'b1; bus.r1_op = 3'b100; bus.r1_a = 32'd6; bus.r1_b = 32'd7;
        #1;
        for (int cyc = 0; cyc < 30 && n_done < 4; cyc++) begin
            if (bus.r0_done || bus.r1_done) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL arb_unexpected_done: got done=%b want no done",
                             {bus.r0_done, bus.r1_done});
                end else begin
                    e = sb.pop_front();
                    if ({bus.r0_done, bus.r1_done} !== {~e.id, e.id} || bus.result !== e.res ||
                        bus.flags !== e.flg || bus.err !== e.er)
                        $display("FAIL arb_result: got done=%b %h/%b want done=%b %h/%b",
                                 {bus.r0_done, bus.r1_done}, bus.result, bus.flags,
                                 {~e.id, e.id}, e.res, e.flg);
                    else passed++;
                end
                n_done++;
            end
            if (bus.r0_ready && bus.r1_ready) both_seen = 1'b1;
            acc0 = bus.r0_ready;
            acc1 = bus.r1_ready;
            if ((acc0 || acc1) && n_acc < 4) begin
                if (acc1) sb.push_back(mk(1'b1, bus.r1_op, bus.r1_a, bus.r1_b));
                else      sb.push_back(mk(1'b0, bus.r0_op, bus.r0_a, bus.r0_b));
                got_order[n_acc] = acc1;
                acc_cyc[n_acc] = cyc;
                if (n_acc > 0 && cyc - acc_cyc[n_acc-1] != 2) bad_spacing = 1'b1;
                n_acc++;
            end
            step();
            if (n_acc >= 4) begin
                bus.r0_valid = 1'b0;
                bus.r1_valid = 1'b0;
            end else begin
                if (acc0) begin bus.r0_a = $urandom; bus.r0_b = $urandom; end
                if (acc1) begin bus.r1_a = $urandom; bus.r1_b = $urandom; end
            end
            #1;
        end
        checks++;
        if (n_done != 4) $display("FAIL arb_timeout: got %0d completions want 4", n_done);
        else passed++;
        checks++;
        if (got_order !== exp_order)
            $display("FAIL arb_order: got %b want %b (bit i = id of op i)", got_order, exp_order);
        else passed++;
        checks++;
        if (both_seen !== 1'b0 || bad_spacing !== 1'b0)
            $display("FAIL arb_grant: got both_ready=%b bad_spacing=%b want 0 0", both_seen, bad_spacing);
        else passed++;
        step();
    endtask

    task automatic test_random();
        logic       rid;
        logic [2:0] op;
        logic       got;
        exp_t       e;
        for (int i = 0; i < 8; i++) begin
            rid = 1'($urandom_range(0, 1));
            op  = 3'($urandom_range(0, 7));
            if (rid) begin
                bus.r1_valid = 1'b1; bus.r1_op = op; bus.r1_a = $urandom; bus.r1_b = $urandom;
            end else begin
                bus.r0_valid = 1'b1; bus.r0_op = op; bus.r0_a = $urandom; bus.r0_b = $urandom;
            end
            #1;
            checks++;
            if ({bus.r0_ready, bus.r1_ready} !== {~rid, rid})
                $display("FAIL rand_ready: got %b want %b", {bus.r0_ready, bus.r1_ready}, {~rid, rid});
            else passed++;
            if (rid) sb.push_back(mk(1'b1, bus.r1_op, bus.r1_a, bus.r1_b));
            else     sb.push_back(mk(1'b0, bus.r0_op, bus.r0_a, bus.r0_b));
            step();
            idle_inputs();
            got = 1'b0;
            for (int k = 0; k < 5 && !got; k++) begin
                step();
                if (bus.r0_done || bus.r1_done) got = 1'b1;
            end
            e = sb.pop_front();
            checks++;
            if (!got)
                $display("FAIL rand_timeout: got no done want done for op %b", op);
            else if ({bus.r0_done, bus.r1_done} !== {~e.id, e.id} || bus.result !== e.res ||
                     bus.flags !== e.flg || bus.err !== e.er)
                $display("FAIL rand_result: got done=%b %h/%b/%b want done=%b %h/%b/%b",
                         {bus.r0_done, bus.r1_done}, bus.result, bus.flags, bus.err,
                         {~e.id, e.id}, e.res, e.flg, e.er);
            else passed++;
        end
    endtask

    task automatic test_reset_exec();
        logic seen;
        exp_t e;
        bus.r1_valid = 1'b1; bus.r1_op = 3'b000; bus.r1_a = 32'd10; bus.r1_b = 32'd20;
        step();
        bus.r1_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.result !== '0 || bus.flags !== 4'b0000 ||
            {bus.r0_done, bus.r1_done} !== 2'b00)
            $display("FAIL rst_exec_clear: got busy=%b %h/%b done=%b want 0 0/0000 00",
                     bus.busy, bus.result, bus.flags, {bus.r0_done, bus.r1_done});
        else passed++;
        sb.delete();
        #1 reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.r0_done || bus.r1_done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL rst_exec_no_done: got done seen=%b want 0", seen);
        else passed++;
        bus.r0_valid = 1'b1; bus.r0_op = 3'b001; bus.r0_a = 32'd9; bus.r0_b = 32'd2;
        #1;
        sb.push_back('{id: 1'b0, res: 32'd7, flg: 4'b0010, er: 1'b0});
        step();
        bus.r0_valid = 1'b0;
        step();
        e = sb.pop_front();
        checks++;
        if (bus.r0_done !== 1'b1 || bus.result !== e.res || bus.flags !== e.flg)
            $display("FAIL rst_exec_next: got done=%b %h/%b want 1 %h/%b",
                     bus.r0_done, bus.result, bus.flags, e.res, e.flg);
        else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_illegal();
        test_sub_zero();
        test_arbitration();
        test_random();
        test_reset_exec();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running want finished");
        $fatal(1);
    end
endmodule
